// File: rtl/mod3_frame_tx_if.sv
// mod3_frame_tx_if: parallel-load / serial-out bundle for mod3_frame_tx.
//   data_in   : payload word, sampled on the accepting edge (master -> slave)
//   load      : frame request, honoured only while ready=1 (master -> slave)
//   ready     : transmitter idle, accepts load this cycle   (slave -> master)
//   x_out     : serial frame bit, payload MSB first, then 2 check bits
//   x_valid   : x_out carries a frame bit this cycle
//   frame_end : high together with the final check bit only
interface mod3_frame_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready;
  logic             x_out;
  logic             x_valid;
  logic             frame_end;

  modport master (
    output data_in,
    output load,
    input  ready,
    input  x_out,
    input  x_valid,
    input  frame_end
  );

  modport slave (
    input  data_in,
    input  load,
    output ready,
    output x_out,
    output x_valid,
    output frame_end
  );
endinterface

// File: rtl/mod3_frame_tx.sv
// mod3_frame_tx: bit-serial transmitter emitting (WIDTH+2)-bit frames whose
// binary value is divisible by 3. A WIDTH-bit word is shifted out MSB first,
// followed by two check bits derived from the running remainder.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mod3_frame_tx_if slave (data_in, load in; ready, x_out, x_valid,
//         frame_end out, all outputs registered)
module mod3_frame_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mod3_frame_tx_if.slave       bus
);

  localparam int unsigned     CW        = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]   LAST_DATA = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CHK_HI    = CW'(WIDTH);
  localparam logic [CW-1:0]   CHK_LO    = CW'(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CHECK
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [1:0]       r_q,     r_d;
  logic [1:0]       chk_d;

  logic             ready_q,     ready_d;
  logic             x_out_q,     x_out_d;
  logic             x_valid_q,   x_valid_d;
  logic             frame_end_q, frame_end_d;

  // r <- (2r + b) mod 3; r is only ever 0..2.
  function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
    logic [1:0] n;
    case ({r, b})
      3'b000:  n = 2'd0;
      3'b001:  n = 2'd1;
      3'b010:  n = 2'd2;
      3'b011:  n = 2'd0;
      3'b100:  n = 2'd1;
      3'b101:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // Two appended bits shift the value left by 2 (x4 == x1 mod 3), so
  // the check value must be (3 - r) mod 3.
  function automatic logic [1:0] check_bits(input logic [1:0] r);
    logic [1:0] c;
    case (r)
      2'd1:    c = 2'b10;
      2'd2:    c = 2'b01;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      r_q         <= '0;
      ready_q     <= 1'b1;
      x_out_q     <= 1'b0;
      x_valid_q   <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      ready_q     <= ready_d;
      x_out_q     <= x_out_d;
      x_valid_q   <= x_valid_d;
      frame_end_q <= frame_end_d;
    end
  end

  // Next-state logic. cnt_q indexes the frame bit being presented this
  // cycle: 0..WIDTH-1 payload, WIDTH and WIDTH+1 check bits.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    unique case (state_q)
      IDLE: begin
        if (bus.load && ready_q) begin
          state_d = DATA;
          shift_d = bus.data_in;
          cnt_d   = '0;
          r_d     = '0;
        end
      end
      DATA: begin
        r_d     = mod3_step(r_q, shift_q[WIDTH-1]);
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_DATA) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (cnt_q == CHK_LO) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line
  // up with the bit being presented in the following cycle.
  always_comb begin
    chk_d       = check_bits(r_d);
    ready_d     = (state_d == IDLE);
    x_valid_d   = (state_d != IDLE);
    x_out_d     = 1'b0;
    frame_end_d = 1'b0;
    case (state_d)
      DATA:  x_out_d = shift_d[WIDTH-1];
      CHECK: begin
        x_out_d     = (cnt_d == CHK_HI) ? chk_d[1] : chk_d[0];
        frame_end_d = (cnt_d == CHK_LO);
      end
      default: ;
    endcase
  end

  assign bus.ready     = ready_q;
  assign bus.x_out     = x_out_q;
  assign bus.x_valid   = x_valid_q;
  assign bus.frame_end = frame_end_q;

endmodule

// File: tb/tb_mod3_frame_tx.sv
// tb_mod3_frame_tx: scoreboard bench for mod3_frame_tx (WIDTH=8).
// Stimulus pushes the expected serial bits of each accepted frame; a monitor
// pops and compares them whenever x_valid is high and runs a reference mod-3
// checker that must read remainder 0 at every frame_end.
module tb_mod3_frame_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mod3_frame_tx_if #(.WIDTH(8)) bus ();

  mod3_frame_tx #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int ref_r = 0;
  logic [1:0] exp_q[$];   // {bit, frame_end}
  logic [1:0] e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [9:0] f);
    for (int i = 0; i < 10; i++) exp_q.push_back({f[9-i], (i == 9) ? 1'b1 : 1'b0});
  endtask

  function automatic logic [9:0] model_frame(input logic [7:0] d);
    logic [1:0] c;
    case (int'(d) % 3)
      1:       c = 2'b10;
      2:       c = 2'b01;
      default: c = 2'b00;
    endcase
    return {d, c};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [9:0] f);
    int unsigned t = 0;
    while (!bus.ready && t < 50) begin @(negedge clk); t++; end
    check("ready_before_load", bus.ready, 1);
    push_frame(f);
    bus.data_in = d;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
    bus.data_in = ~d;
    check("ready_low_after_accept", bus.ready, 0);
  endtask

  task automatic wait_idle();
    int unsigned t = 0;
    do begin @(negedge clk); t++; end while (!bus.ready && t < 50);
    check("ready_after_frame", bus.ready, 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.x_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_bit: x_valid=1 got x_out=%0b expected no frame at %0t", bus.x_out, $time);
        end else begin
          e = exp_q.pop_front();
          check("x_out", bus.x_out, e[1]);
          check("frame_end", bus.frame_end, e[0]);
        end
        ref_r = (2 * ref_r + int'(bus.x_out)) % 3;
        if (bus.frame_end) begin
          check("mod3_remainder", ref_r, 0);
          ref_r = 0;
        end
      end else begin
        check("idle_x_out", bus.x_out, 0);
        check("idle_frame_end", bus.frame_end, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.load    = 1'b0;
    bus.data_in = '0;
    #1 rst = 1'b1;
    #1;
    check("reset_ready", bus.ready, 1);
    check("reset_x_valid", bus.x_valid, 0);
    check("reset_x_out", bus.x_out, 0);
    check("reset_frame_end", bus.frame_end, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed frames
    send(8'h03, 10'b0000_0011_00); wait_idle();
    send(8'h01, 10'b0000_0001_10); wait_idle();
    send(8'h05, 10'b0000_0101_01); wait_idle();
    send(8'hFF, 10'b1111_1111_00); wait_idle();

    // Load pulsed during bit 3 must be ignored
    send(8'h0F, 10'b0000_1111_00);
    repeat (3) @(negedge clk);
    bus.data_in = 8'hAA;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
    check("ready_stays_low", bus.ready, 0);
    wait_idle();

    // Load held high: three back-to-back frames, one idle cycle between
    push_frame(10'b0000_0010_01);
    push_frame(10'b0000_0010_01);
    push_frame(10'b0000_0010_01);
    bus.data_in = 8'h02;
    bus.load    = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (c == 23) bus.load = 1'b0;
      check("held_load_x_valid", bus.x_valid, (c != 11 && c != 22) ? 1 : 0);
    end
    wait_idle();

    // Asynchronous reset during payload bit 5
    send(8'hFF, 10'b1111_1111_00);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_x_valid", bus.x_valid, 0);
    check("abort_x_out", bus.x_out, 0);
    check("abort_frame_end", bus.frame_end, 0);
    check("abort_ready", bus.ready, 1);
    exp_q.delete();
    ref_r = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h03, 10'b0000_0011_00); wait_idle();

    // Full payload sweep
    for (int d = 0; d < 256; d++) begin
      send(8'(d), model_frame(8'(d)));
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
